// File: rtl/keycode_action_scheduler.sv
// Turns the two-slot HID keycode register into per-player game commands:
// press/auto-repeat/cooldown handling, then round-robin onto one valid/ready port.
module keycode_action_scheduler #(
  parameter int unsigned REPEAT_FRAMES   = 4,
  parameter int unsigned COOLDOWN_FRAMES = 8,
  parameter int unsigned CNT_W           = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] keycode,
  input  logic        frame_tick,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        cmd_player,
  output logic [2:0]  cmd_action,
  output logic [4:0]  held_p1,
  output logic [4:0]  held_p2
);

  localparam int unsigned NACT  = 5;
  localparam int unsigned NBITS = 2 * NACT;

  localparam logic [2:0] A_LEFT  = 3'd0;
  localparam logic [2:0] A_RIGHT = 3'd1;
  localparam logic [2:0] A_JUMP  = 3'd2;
  localparam logic [2:0] A_PUNCH = 3'd3;
  localparam logic [2:0] A_KICK  = 3'd4;

  // Bit layout: [4:0] player 1, [9:5] player 2, bit within player = action code.
  function automatic logic [NBITS-1:0] dec_slot(input logic [7:0] k);
    logic [NBITS-1:0] v;
    v = '0;
    case (k)
      8'h04: v[0] = 1'b1;
      8'h07: v[1] = 1'b1;
      8'h1A: v[2] = 1'b1;
      8'h0D: v[3] = 1'b1;
      8'h0E: v[4] = 1'b1;
      8'h50: v[5] = 1'b1;
      8'h4F: v[6] = 1'b1;
      8'h52: v[7] = 1'b1;
      8'h59: v[8] = 1'b1;
      8'h5A: v[9] = 1'b1;
      default: v = '0;
    endcase
    return v;
  endfunction

  logic [15:0]      key_q;
  logic [NBITS-1:0] held_q;
  logic [NBITS-1:0] pend_q, pend_d;
  logic             valid_q, valid_d;
  logic             player_q, player_d;
  logic [2:0]       action_q, action_d;
  logic             rr_q, rr_d;

  logic [NBITS-1:0] held_n, edge_v, set_v, clr_v, rpt_set;
  logic [3:0]       rpt_fire;
  logic [1:0]       blk;

  assign held_n  = dec_slot(key_q[7:0]) | dec_slot(key_q[15:8]);
  assign edge_v  = held_n & ~held_q;
  assign rpt_set = {3'b000, rpt_fire[3:2], 3'b000, rpt_fire[1:0]};
  // Attack edges are dropped (not deferred) while a player is cooling down.
  assign set_v   = (edge_v & ~{blk[1], blk[1], 3'b000, blk[0], blk[0], 3'b000}) | rpt_set;

  // Auto-repeat counters for P1 left/right and P2 left/right.
  for (genvar r = 0; r < 4; r++) begin : g_rpt
    localparam int unsigned B = (r < 2) ? r : r + 3;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fire;

    always_comb begin
      cnt_d = cnt_q;
      fire  = 1'b0;
      if (!held_n[B] || edge_v[B]) begin
        cnt_d = '0;
      end else if (frame_tick) begin
        if (cnt_q == CNT_W'(REPEAT_FRAMES - 1)) begin
          cnt_d = '0;
          fire  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;
    end

    assign rpt_fire[r] = fire;
  end

  // Per-player attack cooldown, armed by an accepted punch/kick.
  for (genvar p = 0; p < 2; p++) begin : g_cd
    logic [CNT_W-1:0] cd_q, cd_d;

    always_comb begin
      cd_d = cd_q;
      if (valid_q && cmd_ready && (player_q == 1'(p)) &&
          ((action_q == A_PUNCH) || (action_q == A_KICK))) begin
        cd_d = CNT_W'(COOLDOWN_FRAMES);
      end else if (frame_tick && (cd_q != '0)) begin
        cd_d = cd_q - CNT_W'(1);
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) cd_q <= '0;
      else          cd_q <= cd_d;
    end

    assign blk[p] = (cd_q != '0);
  end

  logic       has1, has2, any_c, load_c, sel_p;
  logic [4:0] pv;
  logic [2:0] act_c;
  logic [3:0] idx;

  // Round-robin player pick, fixed action priority, output register load.
  always_comb begin
    has1     = |pend_q[4:0];
    has2     = |pend_q[9:5];
    any_c    = has1 | has2;
    load_c   = ~valid_q | cmd_ready;
    sel_p    = rr_q ? ~has1 : has2;
    pv       = sel_p ? pend_q[9:5] : pend_q[4:0];
    act_c    = A_LEFT;
    if      (pv[3]) act_c = A_PUNCH;
    else if (pv[4]) act_c = A_KICK;
    else if (pv[2]) act_c = A_JUMP;
    else if (pv[0]) act_c = A_LEFT;
    else if (pv[1]) act_c = A_RIGHT;
    idx      = sel_p ? (4'(act_c) + 4'd5) : 4'(act_c);
    clr_v    = (load_c && any_c) ? (NBITS'(1) << idx) : '0;
    pend_d   = (pend_q & ~clr_v) | set_v;
    valid_d  = valid_q;
    player_d = player_q;
    action_d = action_q;
    rr_d     = rr_q;
    if (load_c) begin
      valid_d = any_c;
      if (any_c) begin
        player_d = sel_p;
        action_d = act_c;
        rr_d     = sel_p;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_q    <= '0;
      held_q   <= '0;
      pend_q   <= '0;
      valid_q  <= 1'b0;
      player_q <= 1'b0;
      action_q <= 3'd0;
      rr_q     <= 1'b1;
    end else begin
      key_q    <= keycode;
      held_q   <= held_n;
      pend_q   <= pend_d;
      valid_q  <= valid_d;
      player_q <= player_d;
      action_q <= action_d;
      rr_q     <= rr_d;
    end
  end

  assign cmd_valid  = valid_q;
  assign cmd_player = player_q;
  assign cmd_action = action_q;
  assign held_p1    = held_q[4:0];
  assign held_p2    = held_q[9:5];

endmodule

// File: tb/tb_keycode_action_scheduler.sv
// Directed self-checking bench for keycode_action_scheduler.
module tb_keycode_action_scheduler;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] keycode;
  logic        frame_tick;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_player;
  logic [2:0]  cmd_action;
  logic [4:0]  held_p1;
  logic [4:0]  held_p2;

  int checks = 0;
  int errors = 0;
  int ncmd;
  int nleft;

  keycode_action_scheduler #(
    .REPEAT_FRAMES(4),
    .COOLDOWN_FRAMES(8),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .keycode(keycode),
    .frame_tick(frame_tick),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_player(cmd_player),
    .cmd_action(cmd_action),
    .held_p1(held_p1),
    .held_p2(held_p2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    keycode    = 16'h0000;
    frame_tick = 1'b0;
    cmd_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic frame();
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
  endtask

  // Runs n cycles, counting handshakes seen (valid sampled with ready high).
  task automatic run_count(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (cmd_valid && cmd_ready) ncmd++;
    end
  endtask

  initial begin
    do_reset();
    chk("rst_valid", 32'(cmd_valid), 32'd0);
    chk("rst_player", 32'(cmd_player), 32'd0);
    chk("rst_action", 32'(cmd_action), 32'd0);
    chk("rst_held_p1", 32'(held_p1), 32'd0);
    chk("rst_held_p2", 32'(held_p2), 32'd0);

    // Single P1 punch: 3-edge latency, one cycle of valid.
    keycode   = 16'h000D;
    cmd_ready = 1'b1;
    tick(); tick();
    chk("t1_valid_e2", 32'(cmd_valid), 32'd0);
    tick();
    chk("t1_valid_e3", 32'(cmd_valid), 32'd1);
    chk("t1_player", 32'(cmd_player), 32'd0);
    chk("t1_action", 32'(cmd_action), 32'd3);
    chk("t1_held_p1", 32'(held_p1), 32'b01000);
    tick();
    chk("t1_valid_e4", 32'(cmd_valid), 32'd0);

    // Both players in one cycle: P1 wins the first tie, P2 follows with no bubble.
    do_reset();
    keycode   = 16'h0D50;
    cmd_ready = 1'b1;
    repeat (3) tick();
    chk("t2_valid_a", 32'(cmd_valid), 32'd1);
    chk("t2_cmd_a", 32'({cmd_player, cmd_action}), 32'({1'b0, 3'd3}));
    chk("t2_held_p2", 32'(held_p2), 32'b00001);
    tick();
    chk("t2_valid_b", 32'(cmd_valid), 32'd1);
    chk("t2_cmd_b", 32'({cmd_player, cmd_action}), 32'({1'b1, 3'd0}));
    tick();
    chk("t2_valid_c", 32'(cmd_valid), 32'd0);

    // Same key in both slots yields one command.
    do_reset();
    keycode   = 16'h0707;
    cmd_ready = 1'b1;
    ncmd      = 0;
    run_count(8);
    chk("t3_dup_count", 32'(ncmd), 32'd1);

    // Held left with 12 frame ticks: initial plus three repeats.
    do_reset();
    keycode   = 16'h0004;
    cmd_ready = 1'b1;
    ncmd      = 0;
    nleft     = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (cmd_valid) begin ncmd++; if (!cmd_player && cmd_action == 3'd0) nleft++; end
    end
    for (int f = 0; f < 12; f++) begin
      frame_tick = 1'b1;
      for (int c = 0; c < 4; c++) begin
        tick();
        frame_tick = 1'b0;
        if (cmd_valid) begin ncmd++; if (!cmd_player && cmd_action == 3'd0) nleft++; end
      end
    end
    keycode = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (cmd_valid) begin ncmd++; if (!cmd_player && cmd_action == 3'd0) nleft++; end
    end
    chk("t4_rpt_total", 32'(ncmd), 32'd4);
    chk("t4_rpt_left", 32'(nleft), 32'd4);

    // Cooldown: punch blocked through 7 frame ticks, allowed after the 8th.
    do_reset();
    keycode   = 16'h000D;
    cmd_ready = 1'b1;
    ncmd      = 0;
    run_count(4);
    chk("t5_first_punch", 32'(ncmd), 32'd1);
    keycode = 16'h0000;
    run_count(3);
    repeat (4) frame();
    keycode = 16'h000D;
    ncmd    = 0;
    run_count(6);
    chk("t5_block_4", 32'(ncmd), 32'd0);
    keycode = 16'h0000;
    run_count(3);
    repeat (3) frame();
    keycode = 16'h000D;
    ncmd    = 0;
    run_count(6);
    chk("t5_block_7", 32'(ncmd), 32'd0);
    keycode = 16'h0000;
    run_count(3);
    frame();
    keycode = 16'h000D;
    repeat (3) tick();
    chk("t5_after8_valid", 32'(cmd_valid), 32'd1);
    chk("t5_after8_cmd", 32'({cmd_player, cmd_action}), 32'({1'b0, 3'd3}));
    keycode = 16'h0000;
    tick();

    // Backpressure: kick held stable for 10 cycles, then jump.
    do_reset();
    keycode   = 16'h1A0E;
    cmd_ready = 1'b0;
    repeat (3) tick();
    chk("t6_valid", 32'(cmd_valid), 32'd1);
    chk("t6_cmd", 32'({cmd_player, cmd_action}), 32'({1'b0, 3'd4}));
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t6_hold", 32'({cmd_valid, cmd_player, cmd_action}), 32'({1'b1, 1'b0, 3'd4}));
    end
    cmd_ready = 1'b1;
    tick();
    chk("t6_jump", 32'({cmd_valid, cmd_player, cmd_action}), 32'({1'b1, 1'b0, 3'd2}));
    tick();
    chk("t6_drain", 32'(cmd_valid), 32'd0);

    // Reset mid-handshake drops valid at once; nothing stale afterwards.
    do_reset();
    keycode   = 16'h000D;
    cmd_ready = 1'b0;
    repeat (3) tick();
    chk("t7_pre_valid", 32'(cmd_valid), 32'd1);
    #2;
    reset_n = 1'b0;
    keycode = 16'h0000;
    #1;
    chk("t7_async_valid", 32'(cmd_valid), 32'd0);
    chk("t7_async_held", 32'(held_p1), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n   = 1'b1;
    cmd_ready = 1'b1;
    ncmd      = 0;
    run_count(8);
    chk("t7_no_stale", 32'(ncmd), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/keycode_action_scheduler.md
# keycode_action_scheduler

Sequences the 16-bit keycode register value (two USB HID key slots written by the NIOS keyboard driver) into discrete per-player game commands for the stick-figure fighting logic. It sits between the keycode PIO output and the player state machines. It decodes both slots into a held-key vector for each of two players and detects presses. It adds auto-repeat for movement and a cooldown for attacks, then arbitrates both players round-robin onto a single valid/ready command port.

## Interface
- REPEAT_FRAMES, 4: frame_ticks between repeated left/right commands while held (≥1).
- COOLDOWN_FRAMES, 8: frame_ticks a player's punch/kick are blocked after an accepted attack; 0 disables.
- CNT_W, 4: width of repeat/cooldown counters; both frame parameters must be < 2^CNT_W.
- clk  in  1  system clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- keycode  in  16  [7:0] slot 0, [15:8] slot 1; 0x00 = no key.
- frame_tick  in  1  one-cycle pulse per video frame.
- cmd_valid  out  1  command present.
- cmd_ready  in  1  consumer accepts when high with cmd_valid.
- cmd_player  out  1  0 = P1, 1 = P2.
- cmd_action  out  3  0 left, 1 right, 2 jump, 3 punch, 4 kick; 5–7 never driven.
- held_p1, held_p2  out  5  registered held vectors, bit index = action code.

## Operation
- Key map. P1: 0x04 left, 0x07 right, 0x1A jump, 0x0D punch, 0x0E kick. P2: 0x50 left, 0x4F right, 0x52 jump, 0x59 punch, 0x5A kick. Other codes are ignored. Held bit = OR over both slots; the same key in both slots counts as one.
- Press edge = held & ~held_prev. It sets the matching pending bit (10 bits total). Pending coalesces, so a press on an already-pending bit adds nothing.
- Auto-repeat, left/right only. Each held direction has a counter. On frame_tick with the key held and no edge this cycle, the counter increments. At REPEAT_FRAMES the bit is set pending and the counter returns to 0. Release or a press edge clears the counter.
- Cooldown, per player. The counter loads COOLDOWN_FRAMES when a punch/kick command is accepted (cmd_valid & cmd_ready). It decrements on frame_tick down to 0. While nonzero, punch/kick edges for that player are discarded and not made pending. Jump and movement are unaffected.
- Arbitration across players is round-robin. The rr pointer holds the last granted player and prefers the other player when it has pending work. Within a player, priority is fixed: punch > kick > jump > left > right.
- Output register. It loads when empty, or in the same cycle as a handshake (back-to-back, no bubble). A loaded winner clears its pending bit and updates rr. With no pending work after a handshake, cmd_valid drops.
- If a bit is cleared by grant and set by a new event in the same cycle, the set wins.
- While cmd_valid & ~cmd_ready, cmd_player and cmd_action hold stable.

## Timing
- Reset (async assert, sync release): cmd_valid 0, cmd_player 0, cmd_action 0, held_p1/p2 0. All pending bits, counters and registers are 0, and rr = P2 so P1 wins the first tie.
- Asserting reset mid-handshake drops cmd_valid immediately. The in-flight command is lost.
- Pipeline:
  - Edge k registers keycode.
  - Edge k+1 registers held and sets pending.
  - Edge k+2 loads output; cmd_valid is high after edge k+2 when the output is idle. Latency from keycode change to cmd_valid is 3 edges.
- Repeat: first repeat command loads 2 edges after the REPEAT_FRAMES-th frame_tick following the press.
- frame_tick in the same cycle as an edge: the edge wins and the counter clears.
- Throughput: one command per cycle under continuous cmd_ready.

## Test plan
- Reset, then keycode=0x000D, cmd_ready=1 -> cmd_valid high after edge 3 with player 0, action 3, for exactly one cycle; held_p1=5'b01000.
- keycode=0x0D50, cmd_ready=1 -> two commands on consecutive cycles: (P1, punch) then (P2, left).
- Hold keycode=0x0004 with REPEAT_FRAMES=4 for 12 frame_ticks -> 1 initial plus 3 repeat left commands.
- P1 punch accepted; re-press J within 8 frame_ticks -> no command; re-press after the 8th tick -> punch issued.
- cmd_ready=0 for 10 cycles with P1 jump and kick pending -> (P1, kick) held stable, then jump after ready.
- Assert reset_n=0 while cmd_valid=1 -> cmd_valid 0 asynchronously; after release, no stale command.
